// File: rtl/needs_bcd_decoder.sv
// needs_bcd_decoder: snapshots the screen code and the packed need levels,
// converts each 7-bit level (clamped to 100) to 3-digit BCD with a serial
// double-dabble, and presents the decoded frame with a valid/ready handshake.
// A new frame is produced only when the inputs differ from the last snapshot,
// or once after reset.
module needs_bcd_decoder (
  input  logic        clk,
  input  logic        btn_reset,
  input  logic [3:0]  screen_param,
  input  logic [32:0] needs_values,
  input  logic        frame_ready,
  output logic        frame_valid,
  output logic [3:0]  screen_id,
  output logic        disease_flag,
  output logic [3:0]  sel_out,
  output logic [11:0] life_bcd,
  output logic [11:0] food_bcd,
  output logic [11:0] fun_bcd,
  output logic [11:0] rest_bcd,
  output logic [3:0]  clamp_mask,
  output logic        screen_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    PRESENT = 2'd2
  } state_t;

  // Levels above 100 saturate to 100 before conversion.
  function automatic logic [6:0] clamp100(input logic [6:0] v);
    return (v > 7'd100) ? 7'd100 : v;
  endfunction

  // Double-dabble correction: add 3 to every BCD digit that is 5 or more.
  function automatic logic [11:0] dabble_adj(input logic [11:0] b);
    logic [11:0] r;
    for (int i = 0; i < 3; i++) begin
      r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? b[i*4 +: 4] + 4'd3 : b[i*4 +: 4];
    end
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [36:0] snap_q, snap_d;
  logic        force_q, force_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  fld_q, fld_d;
  logic [6:0]  bin_q, bin_d;
  logic [11:0] bcd_q, bcd_d;
  logic [11:0] res_life_q, res_life_d;
  logic [11:0] res_food_q, res_food_d;
  logic [11:0] res_fun_q, res_fun_d;

  logic [3:0]  screen_id_q, screen_id_d;
  logic        disease_q, disease_d;
  logic [3:0]  sel_q, sel_d;
  logic [11:0] life_bcd_q, life_bcd_d;
  logic [11:0] food_bcd_q, food_bcd_d;
  logic [11:0] fun_bcd_q, fun_bcd_d;
  logic [11:0] rest_bcd_q, rest_bcd_d;
  logic [3:0]  clamp_q, clamp_d;
  logic        screen_err_q, screen_err_d;

  // Snapshot field views.
  logic [3:0] snap_screen;
  logic       snap_disease;
  logic [6:0] snap_life, snap_food, snap_fun, snap_rest;
  logic [3:0] snap_sel;

  assign snap_screen  = snap_q[36:33];
  assign snap_disease = snap_q[32];
  assign snap_life    = snap_q[31:25];
  assign snap_food    = snap_q[24:18];
  assign snap_fun     = snap_q[17:11];
  assign snap_rest    = snap_q[10:4];
  assign snap_sel     = snap_q[3:0];

  logic [6:0]  field_raw;
  logic [6:0]  src;
  logic [11:0] adj;
  logic [11:0] shifted;

  // Next-state, conversion step and frame-load logic.
  always_comb begin
    state_d      = state_q;
    snap_d       = snap_q;
    force_d      = force_q;
    bit_d        = bit_q;
    fld_d        = fld_q;
    bin_d        = bin_q;
    bcd_d        = bcd_q;
    res_life_d   = res_life_q;
    res_food_d   = res_food_q;
    res_fun_d    = res_fun_q;
    screen_id_d  = screen_id_q;
    disease_d    = disease_q;
    sel_d        = sel_q;
    life_bcd_d   = life_bcd_q;
    food_bcd_d   = food_bcd_q;
    fun_bcd_d    = fun_bcd_q;
    rest_bcd_d   = rest_bcd_q;
    clamp_d      = clamp_q;
    screen_err_d = screen_err_q;

    case (fld_q)
      2'd0:    field_raw = snap_life;
      2'd1:    field_raw = snap_food;
      2'd2:    field_raw = snap_fun;
      default: field_raw = snap_rest;
    endcase
    // The first step of each field loads the clamped level and starts from zero BCD.
    src     = (bit_q == 3'd0) ? clamp100(field_raw) : bin_q;
    adj     = (bit_q == 3'd0) ? 12'h000 : dabble_adj(bcd_q);
    shifted = {adj[10:0], src[6]};

    case (state_q)
      IDLE: begin
        if (force_q || ({screen_param, needs_values} != snap_q)) begin
          snap_d  = {screen_param, needs_values};
          force_d = 1'b0;
          bit_d   = 3'd0;
          fld_d   = 2'd0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        bin_d = {src[5:0], 1'b0};
        bcd_d = shifted;
        if (bit_q == 3'd6) begin
          bit_d = 3'd0;
          fld_d = fld_q + 2'd1;
          case (fld_q)
            2'd0: res_life_d = shifted;
            2'd1: res_food_d = shifted;
            2'd2: res_fun_d  = shifted;
            default: begin
              // Last shift of the last field: publish the whole frame at once.
              life_bcd_d   = res_life_q;
              food_bcd_d   = res_food_q;
              fun_bcd_d    = res_fun_q;
              rest_bcd_d   = shifted;
              clamp_d      = {snap_life > 7'd100, snap_food > 7'd100,
                              snap_fun > 7'd100, snap_rest > 7'd100};
              screen_err_d = (snap_screen > 4'd6);
              screen_id_d  = (snap_screen > 4'd6) ? 4'd1 : snap_screen;
              sel_d        = (snap_sel > 4'd3) ? 4'd3 : snap_sel;
              disease_d    = snap_disease;
              state_d      = PRESENT;
            end
          endcase
        end else begin
          bit_d = bit_q + 3'd1;
        end
      end
      PRESENT: begin
        if (frame_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, snapshot, working registers and output registers.
  always_ff @(posedge clk) begin
    if (!btn_reset) begin
      state_q      <= IDLE;
      snap_q       <= '0;
      force_q      <= 1'b1;
      bit_q        <= '0;
      fld_q        <= '0;
      bin_q        <= '0;
      bcd_q        <= '0;
      res_life_q   <= '0;
      res_food_q   <= '0;
      res_fun_q    <= '0;
      screen_id_q  <= '0;
      disease_q    <= 1'b0;
      sel_q        <= '0;
      life_bcd_q   <= '0;
      food_bcd_q   <= '0;
      fun_bcd_q    <= '0;
      rest_bcd_q   <= '0;
      clamp_q      <= '0;
      screen_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      snap_q       <= snap_d;
      force_q      <= force_d;
      bit_q        <= bit_d;
      fld_q        <= fld_d;
      bin_q        <= bin_d;
      bcd_q        <= bcd_d;
      res_life_q   <= res_life_d;
      res_food_q   <= res_food_d;
      res_fun_q    <= res_fun_d;
      screen_id_q  <= screen_id_d;
      disease_q    <= disease_d;
      sel_q        <= sel_d;
      life_bcd_q   <= life_bcd_d;
      food_bcd_q   <= food_bcd_d;
      fun_bcd_q    <= fun_bcd_d;
      rest_bcd_q   <= rest_bcd_d;
      clamp_q      <= clamp_d;
      screen_err_q <= screen_err_d;
    end
  end

  assign frame_valid  = (state_q == PRESENT);
  assign busy         = (state_q != IDLE);
  assign screen_id    = screen_id_q;
  assign disease_flag = disease_q;
  assign sel_out      = sel_q;
  assign life_bcd     = life_bcd_q;
  assign food_bcd     = food_bcd_q;
  assign fun_bcd      = fun_bcd_q;
  assign rest_bcd     = rest_bcd_q;
  assign clamp_mask   = clamp_q;
  assign screen_err   = screen_err_q;

endmodule

// File: tb/tb_needs_bcd_decoder.sv
// Directed bench for needs_bcd_decoder with hand-computed expected frames.
module tb_needs_bcd_decoder;

  logic        clk = 1'b0;
  logic        btn_reset;
  logic [3:0]  screen_param;
  logic [32:0] needs_values;
  logic        frame_ready;
  logic        frame_valid;
  logic [3:0]  screen_id;
  logic        disease_flag;
  logic [3:0]  sel_out;
  logic [11:0] life_bcd, food_bcd, fun_bcd, rest_bcd;
  logic [3:0]  clamp_mask;
  logic        screen_err;
  logic        busy;

  int checks = 0;
  int failures = 0;

  needs_bcd_decoder dut (
    .clk          (clk),
    .btn_reset    (btn_reset),
    .screen_param (screen_param),
    .needs_values (needs_values),
    .frame_ready  (frame_ready),
    .frame_valid  (frame_valid),
    .screen_id    (screen_id),
    .disease_flag (disease_flag),
    .sel_out      (sel_out),
    .life_bcd     (life_bcd),
    .food_bcd     (food_bcd),
    .fun_bcd      (fun_bcd),
    .rest_bcd     (rest_bcd),
    .clamp_mask   (clamp_mask),
    .screen_err   (screen_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] scr, input logic dis, input logic [6:0] life,
                        input logic [6:0] food, input logic [6:0] fun, input logic [6:0] rest,
                        input logic [3:0] sel);
    screen_param = scr;
    needs_values = {dis, life, food, fun, rest, sel};
  endtask

  // Returns the number of edges until frame_valid is seen, 0 on timeout.
  task automatic wait_frame(output int n);
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (frame_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic chk_frame(input string tag, input logic [3:0] id, input logic dis,
                           input logic [3:0] sel, input logic [11:0] l, input logic [11:0] f,
                           input logic [11:0] u, input logic [11:0] r, input logic [3:0] cm,
                           input logic err);
    chk({tag, ".screen_id"},  {28'd0, screen_id},  {28'd0, id});
    chk({tag, ".disease"},    {31'd0, disease_flag}, {31'd0, dis});
    chk({tag, ".sel"},        {28'd0, sel_out},    {28'd0, sel});
    chk({tag, ".life"},       {20'd0, life_bcd},   {20'd0, l});
    chk({tag, ".food"},       {20'd0, food_bcd},   {20'd0, f});
    chk({tag, ".fun"},        {20'd0, fun_bcd},    {20'd0, u});
    chk({tag, ".rest"},       {20'd0, rest_bcd},   {20'd0, r});
    chk({tag, ".clamp"},      {28'd0, clamp_mask}, {28'd0, cm});
    chk({tag, ".err"},        {31'd0, screen_err}, {31'd0, err});
  endtask

  initial begin
    int n;
    int cnt;

    // Reset with all inputs zero.
    btn_reset   = 1'b0;
    frame_ready = 1'b0;
    set_in(4'd0, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 4'd0);
    tick();
    tick();
    chk("rst.valid", {31'd0, frame_valid}, 32'd0);
    chk("rst.busy",  {31'd0, busy}, 32'd0);
    chk_frame("rst", 4'd0, 1'b0, 4'd0, 12'h000, 12'h000, 12'h000, 12'h000, 4'd0, 1'b0);

    // First frame: all levels 100, latency 28 edges after the first IDLE sample.
    set_in(4'd1, 1'b0, 7'd100, 7'd100, 7'd100, 7'd100, 4'd2);
    frame_ready = 1'b1;
    btn_reset   = 1'b1;
    wait_frame(n);
    chk("f1.latency", n, 32'd29);
    chk_frame("f1", 4'd1, 1'b0, 4'd2, 12'h100, 12'h100, 12'h100, 12'h100, 4'd0, 1'b0);
    tick();
    chk("f1.accept", {31'd0, frame_valid}, 32'd0);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (frame_valid || busy) cnt++;
    end
    chk("f1.single", cnt, 32'd0);

    // Clamp on food only, small values elsewhere.
    set_in(4'd1, 1'b0, 7'd0, 7'd127, 7'd7, 7'd45, 4'd0);
    wait_frame(n);
    chk("f2.latency", n, 32'd29);
    chk_frame("f2", 4'd1, 1'b0, 4'd0, 12'h000, 12'h100, 12'h007, 12'h045, 4'b0100, 1'b0);
    tick();

    // Back-pressure: outputs held while inputs change, then a second frame follows.
    frame_ready = 1'b0;
    set_in(4'd2, 1'b0, 7'd50, 7'd60, 7'd70, 7'd80, 4'd1);
    wait_frame(n);
    chk("f3.latency", n, 32'd29);
    chk_frame("f3", 4'd2, 1'b0, 4'd1, 12'h050, 12'h060, 12'h070, 12'h080, 4'd0, 1'b0);
    set_in(4'd3, 1'b1, 7'd99, 7'd1, 7'd2, 7'd3, 4'd0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (frame_valid && life_bcd == 12'h050 && rest_bcd == 12'h080 && screen_id == 4'd2)
        cnt++;
    end
    chk("f3.hold", cnt, 32'd10);
    frame_ready = 1'b1;
    tick();
    chk("f3.accept", {31'd0, frame_valid}, 32'd0);
    wait_frame(n);
    chk("f4.latency", n, 32'd29);
    chk_frame("f4", 4'd3, 1'b1, 4'd0, 12'h099, 12'h001, 12'h002, 12'h003, 4'd0, 1'b0);
    tick();

    // Illegal screen code and select clamp.
    set_in(4'd9, 1'b1, 7'd10, 7'd20, 7'd30, 7'd40, 4'd7);
    wait_frame(n);
    chk("f5.latency", n, 32'd29);
    chk_frame("f5", 4'd1, 1'b1, 4'd3, 12'h010, 12'h020, 12'h030, 12'h040, 4'd0, 1'b1);
    tick();

    // Reset in cycle 12 of CONVERT aborts the frame.
    set_in(4'd4, 1'b0, 7'd5, 7'd6, 7'd7, 7'd8, 4'd0);
    tick();
    for (int i = 0; i < 11; i++) tick();
    chk("abort.busy_before", {31'd0, busy}, 32'd1);
    chk("abort.hold", {20'd0, life_bcd}, 32'h010);
    btn_reset = 1'b0;
    tick();
    chk("abort.busy", {31'd0, busy}, 32'd0);
    chk("abort.valid", {31'd0, frame_valid}, 32'd0);
    chk_frame("abort", 4'd0, 1'b0, 4'd0, 12'h000, 12'h000, 12'h000, 12'h000, 4'd0, 1'b0);
    btn_reset = 1'b1;
    wait_frame(n);
    chk("f6.latency", n, 32'd29);
    chk_frame("f6", 4'd4, 1'b0, 4'd0, 12'h005, 12'h006, 12'h007, 12'h008, 4'd0, 1'b0);
    tick();

    // Constant inputs after acceptance: no further frames.
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (frame_valid || busy) cnt++;
    end
    chk("quiet", cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
